// File: rtl/vp_timer_pkg.sv
// Shared definitions for the VProc timer/interrupt block: register map,
// control-bit layout and the byte-enable merge used on register writes.
package vp_timer_pkg;

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_LOAD     = 2'd1;
    localparam logic [1:0] REG_COUNT    = 2'd2;
    localparam logic [1:0] REG_STATUS   = 2'd3;
    localparam logic [5:0] REG_IRQ_PEND = 6'h20;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_AUTO_BIT = 1;
    localparam int CTRL_IE_BIT   = 2;

    // Field order gives ie at bit 2, auto_rl at bit 1, en at bit 0.
    typedef struct packed {
        logic ie;
        logic auto_rl;
        logic en;
    } ctrl_t;

    function automatic logic [31:0] be_merge(input logic [31:0] cur,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/vp_timer_irq_if.sv
// VProc node bus as seen by a memory-mapped peripheral: request side driven
// by the node (master), data/acks returned by the peripheral (slave).
interface vp_timer_irq_if;
    logic [31:0] Addr;
    logic        WE;
    logic        RD;
    logic [3:0]  BE;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        WRAck;
    logic        RDAck;

    modport master (output Addr, WE, RD, BE, DataIn,
                    input  DataOut, WRAck, RDAck);

    modport slave  (input  Addr, WE, RD, BE, DataIn,
                    output DataOut, WRAck, RDAck);
endinterface

// File: rtl/vp_timer_chan.sv
// One timer channel: 32-bit down-counter with reload value, control bits
// and a sticky expiry flag, updated from per-register write strobes.
module vp_timer_chan
    import vp_timer_pkg::*;
(
    input  logic        clk,
    input  logic        nreset,
    input  logic        wr_ctrl,
    input  logic        wr_load,
    input  logic        wr_status,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output ctrl_t       ctrl,
    output logic [31:0] load,
    output logic [31:0] count,
    output logic        expired
);

    logic        at_zero;
    logic        tick;
    logic [31:0] load_next;

    assign at_zero   = (count == '0);
    assign tick      = ctrl.en & at_zero;
    assign load_next = be_merge(load, wdata, be);

    // Branch order encodes precedence: LOAD write over count/reload, CTRL
    // write over the one-shot EN clear, expiry over a W1C clear.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ctrl    <= '0;
            load    <= '0;
            count   <= '0;
            expired <= 1'b0;
        end else begin
            if (wr_load) load <= load_next;

            if (wr_load) begin
                count <= load_next;
            end else if (ctrl.en) begin
                if (!at_zero)          count <= count - 32'd1;
                else if (ctrl.auto_rl) count <= load;
            end

            if (wr_ctrl && be[0]) begin
                ctrl.en      <= wdata[CTRL_EN_BIT];
                ctrl.auto_rl <= wdata[CTRL_AUTO_BIT];
                ctrl.ie      <= wdata[CTRL_IE_BIT];
            end else if (tick && !ctrl.auto_rl) begin
                ctrl.en <= 1'b0;
            end

            if (tick)                               expired <= 1'b1;
            else if (wr_status && be[0] && wdata[0]) expired <= 1'b0;
        end
    end

endmodule

// File: rtl/vp_timer_irq.sv
// Memory-mapped timer bank on a VProc node bus: address decode, one-cycle
// write/read acks, registered read data and level interrupts per timer.
module vp_timer_irq
    import vp_timer_pkg::*;
#(
    parameter int         NUM_TIMERS = 2,
    parameter int         INT_WIDTH  = 3,
    parameter logic [3:0] BASE_SEG   = 4'hc
) (
    input  logic                 clk,
    input  logic                 nreset,
    vp_timer_irq_if.slave        bus,
    output logic [INT_WIDTH-1:0] Interrupt
);

    logic        cs;
    logic [5:0]  offset;
    logic [1:0]  tsel;
    logic [1:0]  rsel;
    logic        timer_hit;
    logic        idle;
    logic        acc_wr;
    logic        acc_rd;
    logic [31:0] rdata;

    ctrl_t       ctrl_a  [NUM_TIMERS];
    logic [31:0] load_a  [NUM_TIMERS];
    logic [31:0] count_a [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] exp_v;
    logic [NUM_TIMERS-1:0] ie_v;
    logic [NUM_TIMERS-1:0] pend;

    ctrl_t       sel_ctrl;
    logic [31:0] sel_load;
    logic [31:0] sel_count;
    logic        sel_exp;

    logic unused_addr;
    assign unused_addr = ^{bus.Addr[27:8], bus.Addr[1:0]};

    assign cs        = (bus.Addr[31:28] == BASE_SEG);
    assign offset    = bus.Addr[7:2];
    assign tsel      = offset[3:2];
    assign rsel      = offset[1:0];
    assign timer_hit = (offset[5:4] == 2'b00) && (int'(tsel) < NUM_TIMERS);

    // An ack in flight blocks acceptance so a request held through its ack
    // cycle is taken only once; a simultaneous WE/RD is treated as a write.
    assign idle   = !bus.WRAck && !bus.RDAck;
    assign acc_wr = cs && bus.WE && idle;
    assign acc_rd = cs && bus.RD && !bus.WE && idle;

    for (genvar n = 0; n < NUM_TIMERS; n++) begin : g_chan
        logic hit;
        assign hit = acc_wr && timer_hit && (tsel == 2'(n));

        vp_timer_chan u_chan (
            .clk       (clk),
            .nreset    (nreset),
            .wr_ctrl   (hit && (rsel == REG_CTRL)),
            .wr_load   (hit && (rsel == REG_LOAD)),
            .wr_status (hit && (rsel == REG_STATUS)),
            .wdata     (bus.DataIn),
            .be        (bus.BE),
            .ctrl      (ctrl_a[n]),
            .load      (load_a[n]),
            .count     (count_a[n]),
            .expired   (exp_v[n])
        );

        assign ie_v[n] = ctrl_a[n].ie;
    end

    assign pend      = exp_v & ie_v;
    assign Interrupt = INT_WIDTH'(pend);

    always_comb begin
        sel_ctrl  = '0;
        sel_load  = '0;
        sel_count = '0;
        sel_exp   = 1'b0;
        for (int n = 0; n < NUM_TIMERS; n++) begin
            if (tsel == 2'(n)) begin
                sel_ctrl  = ctrl_a[n];
                sel_load  = load_a[n];
                sel_count = count_a[n];
                sel_exp   = exp_v[n];
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (offset == REG_IRQ_PEND) begin
            rdata = 32'(pend);
        end else if (timer_hit) begin
            case (rsel)
                REG_CTRL:  rdata = 32'(sel_ctrl);
                REG_LOAD:  rdata = sel_load;
                REG_COUNT: rdata = sel_count;
                default:   rdata = 32'(sel_exp);
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            bus.WRAck   <= 1'b0;
            bus.RDAck   <= 1'b0;
            bus.DataOut <= '0;
        end else begin
            bus.WRAck <= acc_wr;
            bus.RDAck <= acc_rd;
            if (acc_rd) bus.DataOut <= rdata;
        end
    end

endmodule

// File: tb/tb_vp_timer_irq.sv
// Bench for vp_timer_irq: scenario tasks drive the bus, read expectations
// queue up at issue time and are popped when RDAck returns the data.
module tb_vp_timer_irq;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic [2:0] Interrupt;

    vp_timer_irq_if bus();

    vp_timer_irq #(.NUM_TIMERS(2), .INT_WIDTH(3), .BASE_SEG(4'hc)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .bus       (bus),
        .Interrupt (Interrupt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int c0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] addr_of(input int w);
        return 32'hc000_0000 | 32'(w * 4);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                             output bit ok, output int acc);
        bus.Addr = a; bus.DataIn = d; bus.BE = be; bus.WE = 1'b1;
        ok = 1'b0; acc = -1;
        for (int i = 0; i < 8 && !ok; i++) begin
            tick();
            if (bus.WRAck) begin ok = 1'b1; acc = cyc; end
        end
        bus.WE = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d,
                            output bit ok, output int acc);
        bus.Addr = a; bus.RD = 1'b1;
        ok = 1'b0; acc = -1; d = 'x;
        for (int i = 0; i < 8 && !ok; i++) begin
            tick();
            if (bus.RDAck) begin ok = 1'b1; acc = cyc; d = bus.DataOut; end
        end
        bus.RD = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        bus.Addr = 32'hc000_0000; bus.RD = 1'b1; bus.WE = 1'b0;
        bus.BE = 4'h0; bus.DataIn = '0;
        nreset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (bus.RDAck !== 1'b0 || bus.DataOut !== 32'h0 || Interrupt !== 3'b000) begin
                n_bad++;
                $display("FAIL reset_hold: RDAck=%b DataOut=%h Interrupt=%b, required 0/0/0",
                         bus.RDAck, bus.DataOut, Interrupt);
            end
        end
        exp_q.push_back(32'h0);
        nreset = 1'b1;
        tick();
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.RDAck !== 1'b1 || bus.DataOut !== e) begin
            n_bad++;
            $display("FAIL reset_first_read: RDAck=%b DataOut=%h, required 1/%h", bus.RDAck, bus.DataOut, e);
        end
        tick();
        bus.RD = 1'b0;
        n_cmp++;
        if (bus.RDAck !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_single_ack: RDAck=%b, required 0", bus.RDAck);
        end
        tick();
    endtask

    task automatic test_auto_reload();
        bit ok; int acc; logic [31:0] d, e;
        bus_write(addr_of(1), 32'd5, 4'hf, ok, acc);
        bus_write(addr_of(0), 32'h7, 4'hf, ok, c0);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL auto_ctrl_write: no WRAck, required ack"); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_cmp++;
            if (Interrupt[0] !== (k == 6)) begin
                n_bad++;
                $display("FAIL auto_irq_rise k=%0d: Interrupt[0]=%b, required %b", k, Interrupt[0], k == 6);
            end
        end
        for (int j = 0; j < 6; j++) begin
            repeat (6) tick();
            exp_q.push_back(32'(5 - ((cyc - c0) % 6)));
            bus_read(addr_of(2), d, ok, acc);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || d !== e) begin
                n_bad++;
                $display("FAIL auto_count_read %0d: got %h ack=%b, required %h", j, d, ok, e);
            end
        end
        for (int i = 0; i < 6 && ((cyc + 1 - c0) % 6) != 2; i++) tick();
        bus_write(addr_of(3), 32'h1, 4'h1, ok, acc);
        n_cmp++;
        if (Interrupt[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL auto_w1c_clear: Interrupt[0]=%b, required 0", Interrupt[0]);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k >= 3) begin
                n_cmp++;
                if (Interrupt[0] !== (k == 4)) begin
                    n_bad++;
                    $display("FAIL auto_period k=%0d: Interrupt[0]=%b, required %b", k, Interrupt[0], k == 4);
                end
            end
        end
    endtask

    task automatic test_w1c_collision();
        bit ok; int acc; logic [31:0] d, e;
        repeat (2) tick();
        for (int i = 0; i < 6 && ((cyc + 1 - c0) % 6) != 0; i++) tick();
        bus_write(addr_of(3), 32'h1, 4'h1, ok, acc);
        n_cmp++;
        if (Interrupt[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL w1c_collision_irq: Interrupt[0]=%b, required 1", Interrupt[0]);
        end
        exp_q.push_back(32'h1);
        bus_read(addr_of(3), d, ok, acc);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || d !== e) begin
            n_bad++;
            $display("FAIL w1c_collision_status: got %h, required %h", d, e);
        end
        bus_write(addr_of(0), 32'h0, 4'hf, ok, acc);
        bus_write(addr_of(3), 32'h1, 4'h1, ok, acc);
        tick();
        n_cmp++;
        if (Interrupt[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL stop_timer0: Interrupt[0]=%b, required 0", Interrupt[0]);
        end
    endtask

    task automatic test_one_shot();
        bit ok; int acc, c1; logic [31:0] d, e;
        bus_write(addr_of(5), 32'd3, 4'hf, ok, acc);
        bus_write(addr_of(4), 32'h5, 4'hf, ok, c1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k >= 3) begin
                n_cmp++;
                if (Interrupt[1] !== (k == 4)) begin
                    n_bad++;
                    $display("FAIL oneshot_rise k=%0d: Interrupt[1]=%b, required %b", k, Interrupt[1], k == 4);
                end
            end
        end
        repeat (10) tick();
        n_cmp++;
        if (Interrupt[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL oneshot_level: Interrupt[1]=%b, required 1", Interrupt[1]);
        end
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h2);
        for (int j = 0; j < 3; j++) begin
            bus_read(addr_of(j == 0 ? 4 : (j == 1 ? 6 : 32)), d, ok, acc);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || d !== e) begin
                n_bad++;
                $display("FAIL oneshot_read %0d: got %h, required %h", j, d, e);
            end
        end
        bus_write(addr_of(7), 32'h1, 4'h1, ok, acc);
        n_cmp++;
        if (Interrupt[1] !== 1'b0) begin
            n_bad++;
            $display("FAIL oneshot_clear: Interrupt[1]=%b, required 0", Interrupt[1]);
        end
    endtask

    task automatic test_byte_enable();
        bit ok; int acc; logic [31:0] d, e;
        bus_write(addr_of(1), 32'h0, 4'hf, ok, acc);
        bus_write(addr_of(1), 32'hAABBCCDD, 4'b0101, ok, acc);
        exp_q.push_back(32'h00BB00DD);
        exp_q.push_back(32'h00BB00DD);
        for (int j = 0; j < 2; j++) begin
            bus_read(addr_of(1 + j), d, ok, acc);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || d !== e) begin
                n_bad++;
                $display("FAIL byte_enable %0d: got %h, required %h", j, d, e);
            end
        end
    endtask

    task automatic test_held_and_decode();
        bit ok; int acc, acks; logic [31:0] d, e;
        tick();
        bus.Addr = 32'hc000_0004; bus.DataIn = 32'h11; bus.BE = 4'hf; bus.WE = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.WRAck) acks++;
            if (i == 1) bus.WE = 1'b0;
        end
        n_cmp++;
        if (acks != 1) begin
            n_bad++;
            $display("FAIL held_write: %0d WRAck cycles, required 1", acks);
        end
        bus_write(32'hd000_0000, 32'h7, 4'hf, ok, acc);
        n_cmp++;
        if (ok) begin
            n_bad++;
            $display("FAIL decode_miss: WRAck seen, required none");
        end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h11);
        exp_q.push_back(32'h0);
        for (int j = 0; j < 3; j++) begin
            bus_read(j == 0 ? addr_of(0) : (j == 1 ? addr_of(1) : 32'hc000_00c0), d, ok, acc);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || d !== e) begin
                n_bad++;
                $display("FAIL decode_read %0d: got %h ack=%b, required %h", j, d, ok, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2, ok; int a1, a2, acc; logic [31:0] d, e;
        tick();
        bus_write(addr_of(5), 32'h1234, 4'hf, ok1, a1);
        bus_write(addr_of(5), 32'h5678, 4'hf, ok2, a2);
        n_cmp++;
        if (!ok1 || !ok2 || (a2 - a1) != 2) begin
            n_bad++;
            $display("FAIL back_to_back: spacing %0d cycles, required 2", a2 - a1);
        end
        tick();
        bus.Addr = addr_of(5); bus.DataIn = 32'h55; bus.BE = 4'hf;
        bus.WE = 1'b1; bus.RD = 1'b1;
        tick();
        bus.WE = 1'b0; bus.RD = 1'b0;
        n_cmp++;
        if (bus.WRAck !== 1'b1 || bus.RDAck !== 1'b0) begin
            n_bad++;
            $display("FAIL write_wins: WRAck=%b RDAck=%b, required 1/0", bus.WRAck, bus.RDAck);
        end
        tick();
        exp_q.push_back(32'h55);
        bus_read(addr_of(5), d, ok, acc);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || d !== e) begin
            n_bad++;
            $display("FAIL write_wins_data: got %h, required %h", d, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_auto_reload();
        test_w1c_collision();
        test_one_shot();
        test_byte_enable();
        test_held_and_decode();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
